// File: rtl/cw_pkg.sv
// ---------------------------------------------------------------------------
// cw_pkg
// Shared constants and types for the constant-weight codeword byte packer.
//   CW_W / CW_T      : codeword word width and words per frame
//   CW_FRAME_BYTES   : bytes produced by one full frame, ceil(CW_T*CW_W/8)
//   CW_ACC_W         : default bit-accumulator width
//   CW_FIFO_DEPTH    : default output byte FIFO depth
//   pack_state_e     : packer FSM state (IDLE, PACK, FLUSH)
//   fifo_entry_t     : one FIFO entry {last, data}
// ---------------------------------------------------------------------------
package cw_pkg;

  localparam int CW_W           = 10;
  localparam int CW_T           = 38;
  localparam int CW_FRAME_BYTES = (CW_T * CW_W + 7) / 8;  // 48
  localparam int CW_ACC_W       = 24;
  localparam int CW_FIFO_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2
  } pack_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cw_byte_fifo.sv
// ---------------------------------------------------------------------------
// cw_byte_fifo
// Synchronous first-word-fall-through FIFO of {last, data} byte entries.
// The head entry is visible on rdata_o whenever empty_o is low.
// A push while full and a pop while empty are ignored.
// DEPTH must be a power of two.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i this cycle (ignored when full)
//   wdata_i    : entry to write
//   pop_i      : discard the head entry this cycle (ignored when empty)
//   rdata_o    : head entry
//   full_o     : no free slot
//   empty_o    : no valid entry
// ---------------------------------------------------------------------------
module cw_byte_fifo
  import cw_pkg::*;
#(
  parameter int DEPTH = CW_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t wdata_i,
  input  logic        pop_i,
  output fifo_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("cw_byte_fifo: DEPTH must be a power of two");
  end

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  fifo_entry_t mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cw_byte_packer.sv
// ---------------------------------------------------------------------------
// cw_byte_packer
// Packs the encoder's W-bit codeword position words into bytes, LSB-first,
// and queues them in a FWFT byte FIFO for a valid/ready byte stream with an
// end-of-frame marker.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset (discards everything)
//   cw_word     : codeword word, valid while cw_rdy is high
//   cw_rdy      : one-cycle word strobe (no backpressure upstream)
//   cw_done     : one-cycle end-of-frame strobe, with or after the last word
//   byte_out    : packed byte at the FIFO head (0 when empty)
//   byte_valid  : byte_out / byte_last are valid
//   byte_ready  : consumer accepts byte_out this cycle
//   byte_last   : byte_out is the final byte of the frame
//   busy        : FSM is in PACK or FLUSH
//   err_ovf     : sticky, a word was dropped (accumulator full or during FLUSH)
//   err_cnt     : sticky, a frame's word count differed from T
//   dbg_state   : current FSM state
//
// Byte handshake: a byte transfers on every rising edge where byte_valid and
// byte_ready are both high; byte_valid never depends on byte_ready, and
// byte_out/byte_last hold steady while byte_valid is high and not accepted.
//
// Build option: define CWPACK_CNT_CHECK_EN to build the per-frame word
// counter and the err_cnt check; otherwise err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module cw_byte_packer
  import cw_pkg::*;
#(
  parameter int W          = CW_W,
  parameter int T          = CW_T,
  parameter int ACC_W      = CW_ACC_W,
  parameter int FIFO_DEPTH = CW_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cw_word,
  input  logic         cw_rdy,
  input  logic         cw_done,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         byte_last,
  output logic         busy,
  output logic         err_ovf,
  output logic         err_cnt,
  output pack_state_e  dbg_state
);

  if (FIFO_DEPTH < (T * W + 7) / 8) begin : g_bad_fifo_depth
    $error("cw_byte_packer: FIFO_DEPTH cannot hold one frame");
  end

  // Wide enough to hold cnt + W without wrapping.
  localparam int CNT_W = $clog2(ACC_W + W + 1);
  localparam logic [CNT_W-1:0] C_EIGHT = CNT_W'(8);
  localparam logic [CNT_W-1:0] C_W     = CNT_W'(W);
  localparam logic [CNT_W-1:0] C_ACC   = CNT_W'(ACC_W);

  pack_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_after;
  logic             err_ovf_q, err_ovf_d;
  logic             push;
  logic             last_push;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;
  logic             fifo_full;
  logic             fifo_empty;

  // -------------------------------------------------------------------------
  // Accumulator, push decision and FSM next state.
  // Bits of acc above cnt are always zero, so acc[7:0] is already the
  // zero-padded tail byte when FLUSH pushes a partial byte.
  // -------------------------------------------------------------------------
  always_comb begin
    push      = 1'b0;
    last_push = 1'b0;
    cnt_after = cnt_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q;
    state_d   = state_q;

    if (!fifo_full) begin
      if (cnt_q >= C_EIGHT) begin
        push = 1'b1;
      end else if (state_q == ST_FLUSH && cnt_q != '0) begin
        push = 1'b1;
      end
    end

    if (push) begin
      acc_d     = acc_q >> 8;
      cnt_after = (cnt_q >= C_EIGHT) ? (cnt_q - C_EIGHT) : '0;
    end
    cnt_d = cnt_after;

    // No words are accepted in FLUSH, so the push that empties the
    // accumulator there is the frame's final byte.
    last_push = push && (state_q == ST_FLUSH) && (cnt_after == '0);

    // Room is judged after this cycle's push has freed its 8 bits.
    if (cw_rdy) begin
      if (state_q != ST_FLUSH && (cnt_after + C_W) <= C_ACC) begin
        acc_d = acc_d | (ACC_W'(cw_word) << cnt_after);
        cnt_d = cnt_after + C_W;
      end else begin
        err_ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // A word arriving with cw_done is accepted, then the frame flushes.
        if (cw_rdy) state_d = cw_done ? ST_FLUSH : ST_PACK;
      end
      ST_PACK: begin
        if (cw_done) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // cnt == 0 on entry means every byte already left without a marker.
        if (last_push || cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef CWPACK_CNT_CHECK_EN
  // -------------------------------------------------------------------------
  // Per-frame word counter (saturating); every strobe outside FLUSH counts,
  // including words dropped on overflow.
  // -------------------------------------------------------------------------
  logic [5:0] wcnt_q, wcnt_d, wcnt_inc;
  logic       err_cnt_q, err_cnt_d;

  always_comb begin
    wcnt_inc  = wcnt_q;
    err_cnt_d = err_cnt_q;
    if (cw_rdy && state_q != ST_FLUSH && wcnt_q != 6'h3F) begin
      wcnt_inc = wcnt_q + 6'd1;
    end
    wcnt_d = wcnt_inc;
    // Includes a word strobed together with cw_done; in IDLE with no
    // word this compares a count of zero.
    if (cw_done && state_q != ST_FLUSH && wcnt_inc != 6'(T)) begin
      err_cnt_d = 1'b1;
    end
    if (state_q == ST_FLUSH && state_d == ST_IDLE) wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      err_cnt_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Output byte FIFO
  // -------------------------------------------------------------------------
  assign push_entry.last = last_push;
  assign push_entry.data = acc_q[7:0];

  cw_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (byte_valid && byte_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign byte_valid = !fifo_empty;
  assign byte_out   = fifo_empty ? 8'h00 : head.data;
  assign byte_last  = fifo_empty ? 1'b0  : head.last;
  assign busy       = (state_q != ST_IDLE);
  assign err_ovf    = err_ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cw_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_cw_byte_packer
// Self-checking bench for cw_byte_packer. Expected bytes come from a bit
// stream model: every accepted word is appended LSB-first to a bit queue,
// which is cut into bytes, the tail zero-padded and marked last.
// ---------------------------------------------------------------------------
module tb_cw_byte_packer;
  import cw_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CW_W-1:0]   cw_word = '0;
  logic              cw_rdy = 1'b0;
  logic              cw_done = 1'b0;
  logic              byte_ready = 1'b0;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_last;
  logic              busy;
  logic              err_ovf;
  logic              err_cnt;
  pack_state_e       dbg_state;

  always #5 clk = ~clk;

  cw_byte_packer dut (
    .clk        (clk),
    .rst        (rst),
    .cw_word    (cw_word),
    .cw_rdy     (cw_rdy),
    .cw_done    (cw_done),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy),
    .err_ovf    (err_ovf),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- bench state ----------------
  int              n_tests  = 0;
  int              n_fail   = 0;
  int              n_popped = 0;
  int              rdy_mode = 1;    // 0: always ready, 1: never, 2: random
  logic [8:0]      exp_q[$];        // expected {last, data}
  logic [CW_W-1:0] frame_q[$];      // words of the frame being driven
  logic            exp_err_cnt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       byte_ready = 1'b1;
      1:       byte_ready = 1'b0;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_err_cnt = 1'b0;
  endtask

  // Reference model: frame_q as one LSB-first bit stream cut into bytes.
  task automatic model_frame();
    bit         bq[$];
    logic [7:0] b;
    logic       lst;
    foreach (frame_q[i]) begin
      for (int j = 0; j < CW_W; j++) bq.push_back(frame_q[i][j]);
    end
    while (bq.size() > 0) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        if (bq.size() > 0) b[j] = bq.pop_front();
      end
      lst = (bq.size() == 0);
      exp_q.push_back({lst, b});
    end
  endtask

  task automatic note_frame_count(input int n);
`ifdef CWPACK_CNT_CHECK_EN
    if (n != CW_T) exp_err_cnt = 1'b1;
`else
    if (n < 0) exp_err_cnt = 1'b1;  // never: the check is not built
`endif
  endtask

  // Drives n words with gaps in [gmin,gmax] cycles between strobes; cw_done
  // comes with the last word (done_delay 0) or done_delay cycles after it.
  task automatic send_frame(input int n, input int gmin, input int gmax,
                            input int done_delay, input bit fixed_en,
                            input logic [CW_W-1:0] fixed_word);
    frame_q.delete();
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(fixed_en ? fixed_word : CW_W'($urandom));
    end
    model_frame();
    note_frame_count(n);
    for (int i = 0; i < n; i++) begin
      cw_word = frame_q[i];
      cw_rdy  = 1'b1;
      cw_done = (i == n - 1) && (done_delay == 0);
      tick();
      cw_rdy  = 1'b0;
      cw_done = 1'b0;
      if (i < n - 1) repeat ($urandom_range(gmin, gmax) - 1) tick();
    end
    if (done_delay > 0) begin
      repeat (done_delay - 1) tick();
      cw_done = 1'b1;
      tick();
      cw_done = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(tag, busy, 0);
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: a byte seen valid && ready here transfers
  // on the next rising edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && byte_valid && byte_ready) begin
      e = 32'hDEAD_BEEF;
      if (exp_q.size() > 0) e = {23'b0, exp_q.pop_front()};
      check("byte", {23'b0, byte_last, byte_out}, e);
      n_popped++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    do_reset();
    check("rst_valid", byte_valid, 0);
    check("rst_last", byte_last, 0);
    check("rst_data", byte_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 0x155, 0x2AA with cw_done on the second strobe; also first-byte latency.
    rdy_mode = 1;
    exp_q.push_back(9'h055);
    exp_q.push_back(9'h0A9);
    exp_q.push_back(9'h10A);
    note_frame_count(2);
    cw_word = 10'h155;
    cw_rdy  = 1'b1;
    tick();
    check("lat_t1_valid", byte_valid, 0);
    check("lat_busy", busy, 1);
    cw_word = 10'h2AA;
    cw_done = 1'b1;
    tick();
    cw_rdy  = 1'b0;
    cw_done = 1'b0;
    check("lat_t2_valid", byte_valid, 1);
    check("lat_t2_data", byte_out, 8'h55);
    rdy_mode = 0;
    wait_drain(100, "drain_short");
    wait_idle(100, "idle_short");
    check("short_cnt", err_cnt, exp_err_cnt);

    // Default frame of 38 x 0x3FF, one every 12 cycles, late cw_done.
    do_reset();
    rdy_mode = 0;
    send_frame(CW_T, 12, 12, 12, 1'b1, 10'h3FF);
    wait_drain(600, "drain_full");
    wait_idle(100, "idle_full");
    check("full_ovf", err_ovf, 0);
    check("full_cnt", err_cnt, exp_err_cnt);

    // Whole frame held back by byte_ready=0, then released.
    rdy_mode = 1;
    base = n_popped;
    send_frame(CW_T, 2, 5, 0, 1'b0, '0);
    wait_idle(200, "bp_busy_falls");
    check("bp_queued", byte_valid, 1);
    rdy_mode = 0;
    wait_drain(200, "drain_bp");
    check("bp_count", n_popped - base, CW_FRAME_BYTES);

    // Random frames with random consumer stalls.
    for (int f = 0; f < 6; f++) begin
      rdy_mode = 2;
      send_frame($urandom_range(1, 40), 2, 5, $urandom_range(0, 1), 1'b0, '0);
      wait_drain(2000, "drain_rand");
      wait_idle(100, "idle_rand");
      check("rand_cnt", err_cnt, exp_err_cnt);
      check("rand_ovf", err_ovf, 0);
    end

    // 37-word frame.
    do_reset();
    rdy_mode = 0;
    send_frame(CW_T - 1, 2, 4, 0, 1'b0, '0);
    wait_drain(500, "drain_37");
    wait_idle(100, "idle_37");
    check("cnt_37", err_cnt, exp_err_cnt);

    // Words on consecutive cycles: the accumulator gains 2 bits per cycle,
    // holding 2k bits before word k+1, so words 1..8 fit and word 9 (16+10 > 24)
    // is dropped.
    do_reset();
    rdy_mode = 0;
    frame_q.delete();
    for (int i = 0; i < 8; i++) frame_q.push_back(CW_W'($urandom));
    model_frame();
    note_frame_count(9);
    for (int i = 0; i < 9; i++) begin
      cw_word = (i < 8) ? frame_q[i] : CW_W'($urandom);
      cw_rdy  = 1'b1;
      cw_done = (i == 8);
      tick();
      if (i == 7) check("ovf_before", err_ovf, 0);
    end
    cw_rdy  = 1'b0;
    cw_done = 1'b0;
    check("ovf_set", err_ovf, 1);
    wait_drain(200, "drain_ovf");
    wait_idle(100, "idle_ovf");
    rdy_mode = 2;
    send_frame(5, 2, 4, 1, 1'b0, '0);
    wait_drain(500, "drain_after_ovf");
    wait_idle(100, "idle_after_ovf");
    check("ovf_sticky", err_ovf, 1);

    // Reset mid-frame with 5 bytes queued.
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      cw_word = CW_W'($urandom);
      cw_rdy  = 1'b1;
      tick();
      cw_rdy  = 1'b0;
      tick();
    end
    repeat (6) tick();
    check("mid_queued", byte_valid, 1);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_err_cnt = 1'b0;
    check("mid_valid", byte_valid, 0);
    check("mid_busy0", busy, 0);
    check("mid_ovf", err_ovf, 0);
    check("mid_cnt", err_cnt, 0);
    rdy_mode = 2;
    send_frame(CW_T, 2, 5, 0, 1'b0, '0);
    wait_drain(2000, "drain_post_rst");
    wait_idle(100, "idle_post_rst");
    check("post_rst_ovf", err_ovf, 0);
    check("post_rst_cnt", err_cnt, exp_err_cnt);

    // cw_done with no words: nothing is queued, count 0 is evaluated.
    rdy_mode = 0;
    cw_done = 1'b1;
    tick();
    cw_done = 1'b0;
    note_frame_count(0);
    repeat (4) tick();
    check("empty_valid", byte_valid, 0);
    check("empty_busy", busy, 0);
    check("empty_cnt", err_cnt, exp_err_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
